theta_serial: RTL and testbench
===============================

// Module: theta_serial
// PURPOSE
//  Keccak-f theta step, row-serial and registered; the stage directly upstream of rho in the permutation datapath.
//  Takes a full 25-lane state over a valid/ready handshake.
//  Accumulates the five column parities one row (y) per cycle, then applies D[x] one row per cycle.
//  Presents the result to rho over a valid/ready handshake; one 5-lane XOR/rotate datapath instead of 25.
// PARAMETERS
//  LANE_W   64   lane width in bits; state width is 25*LANE_W (64 -> Keccak-f[1600])
// PORTS
//  clk        in   1          single clock, all state on rising edge
//  rst        in   1          synchronous, active-high reset
//  in_valid   in   1          state_in is valid
//  in_ready   out  1          block can accept a state (IDLE only)
//  state_in   in   25*LANE_W  lane i = x+5*y at bits [i*LANE_W +: LANE_W]
//  out_valid  out  1          state_out holds a finished theta result
//  out_ready  in   1          downstream (rho) accepts state_out
//  state_out  out  25*LANE_W  theta(state), same lane packing as state_in
// BEHAVIOUR
//  Reset: sync, active-high.
//   - Edge with rst=1: FSM->IDLE, row counter=0, C[0..4]=0, state register=0.
//   - While rst=1: out_valid=0, in_ready=0, state_out=0.
//   - rst overrides any handshake in the same cycle; an in-flight state is discarded.
//  FSM: IDLE -> PARITY -> APPLY -> DONE -> IDLE; row counter r in 0..4.
//   - IDLE: in_ready=1. Edge with in_valid=1: capture state_in, clear C, r=0, go PARITY.
//   - PARITY: each edge C[x] ^= lane[x+5r] for x=0..4. r++. After r=4: r=0, go APPLY.
//   - APPLY: each edge lane[x+5r] ^= D[x] for x=0..4. r++. After r=4: go DONE.
//     D[x] = C[(x+4)%5] ^ rotl(C[(x+1)%5],1), rotate within LANE_W. C is stable during APPLY.
//   - DONE: out_valid=1. state_out = register, held stable while out_ready=0.
//     Edge with out_ready=1: go IDLE. out_valid drops the next cycle.
//  Timing
//   - Input accepted at edge T; out_valid first high in the cycle after edge T+10 (10 cycles of work).
//   - Max throughput: one state per 12 cycles, counting the IDLE accept cycle.
//   - in_ready=0 outside IDLE; in_valid is ignored in PARITY, APPLY and DONE.
//   - No overlap with DONE: a new input is taken only after output retire.
//  Outputs
//   - out_valid and in_ready are decoded from FSM state only.
//   - No combinational path from out_ready to in_ready, or from in_valid to out_valid.
//  Boundaries
//   - r wraps 4->0 exactly at the PARITY->APPLY transition.
//   - Extra out_ready pulses in non-DONE states have no effect.
//   - state_out equals the register contents in every state (mid-compute values are visible but not valid).
// TESTING
//  1 all-zero state_in, out_ready=1 -> state_out all zero, out_valid high 10 cycles after accept.
//  2 lane0=64'h1, other lanes 0:
//     - lanes 0,1,6,11,16,21 = 64'h1
//     - lanes 4,9,14,19,24 = 64'h2
//     - all other lanes 0
//  3 lanes 0..2 = 64'hAAAA_AAAA_AAAA_AAAA, rest 0:
//     - row y=0 lanes x=0..4: FFFF..FF, 5555..55, 0, AAAA..AA, 5555..55
//     - rows y=1..4, x=0..4: 5555..55, FFFF..FF, AAAA..AA, AAAA..AA, 5555..55
//  4 out_ready=0 for 20 cycles in DONE:
//     - out_valid and state_out held constant, in_ready=0
//     - release: one transfer, then in_ready=1 the next cycle
//  5 rst=1 during APPLY (r=2):
//     - next cycle: out_valid=0, state_out=0
//     - after release: in_ready=1
//     - new vector (test 2) gives the exact test-2 result
//  6 back-to-back: in_valid held high with 3 random states, out_ready random 50%:
//     - 3 outputs, in order, matching the golden theta model
//     - no drops or duplicates

Source files
------------

// File: rtl/theta_serial.sv
// theta_serial: row-serial registered Keccak-f theta step with valid/ready on both sides
module theta_serial #(
  parameter int LANE_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [25*LANE_W-1:0]  state_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [25*LANE_W-1:0]  state_out
);
  typedef enum logic [1:0] {IDLE, PARITY, APPLY, DONE} fsm_t;
  fsm_t                 fsm;
  logic [2:0]           r;
  logic [LANE_W-1:0]    c    [5];
  logic [LANE_W-1:0]    lane [5];
  logic [LANE_W-1:0]    d    [5];
  logic [25*LANE_W-1:0] st;
  assign state_out = st;
  always_comb
    for (int x = 0; x < 5; x++) lane[x] = st[(5*r+x)*LANE_W +: LANE_W];
  for (genvar x = 0; x < 5; x++) begin : g_d
    assign d[x] = c[(x+4)%5] ^ {c[(x+1)%5][LANE_W-2:0], c[(x+1)%5][LANE_W-1]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      r         <= '0;
      st        <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      for (int x = 0; x < 5; x++) c[x] <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          in_ready <= !(in_valid && in_ready);
          if (in_valid && in_ready) begin
            st  <= state_in;
            r   <= '0;
            fsm <= PARITY;
            for (int x = 0; x < 5; x++) c[x] <= '0;
          end
        end
        PARITY: begin
          for (int x = 0; x < 5; x++) c[x] <= c[x] ^ lane[x];
          r   <= (r == 3'd4) ? 3'd0 : r + 3'd1;
          fsm <= (r == 3'd4) ? APPLY : PARITY;
        end
        APPLY: begin
          for (int x = 0; x < 5; x++) st[(5*r+x)*LANE_W +: LANE_W] <= lane[x] ^ d[x];
          r         <= (r == 3'd4) ? 3'd0 : r + 3'd1;
          fsm       <= (r == 3'd4) ? DONE : APPLY;
          out_valid <= (r == 3'd4);
        end
        DONE: begin
          fsm       <= out_ready ? IDLE : DONE;
          out_valid <= !out_ready;
          in_ready  <= out_ready;
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_theta_serial.sv
// tb_theta_serial: directed and randomized checks of theta_serial against a column-wise theta model
module tb_theta_serial;
  localparam int W  = 64;
  localparam int SW = 25*W;
  typedef logic [SW-1:0] st_t;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, out_valid, out_ready = 0;
  st_t  state_in = '0, state_out;
  int   errors = 0, checks = 0;
  theta_serial #(.LANE_W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .state_in(state_in),
    .out_valid(out_valid), .out_ready(out_ready), .state_out(state_out)
  );
  always #5 clk = ~clk;
  function automatic st_t theta(input st_t s);
    logic [W-1:0] cp [5];
    logic [W-1:0] dm [5];
    st_t o;
    for (int x = 0; x < 5; x++) begin
      cp[x] = '0;
      for (int y = 0; y < 5; y++) cp[x] ^= s[(x+5*y)*W +: W];
    end
    for (int x = 0; x < 5; x++)
      dm[x] = cp[(x+4)%5] ^ ((cp[(x+1)%5] << 1) | (cp[(x+1)%5] >> (W-1)));
    for (int i = 0; i < 25; i++) o[i*W +: W] = s[i*W +: W] ^ dm[i%5];
    return o;
  endfunction
  function automatic st_t rand_state();
    st_t s;
    for (int i = 0; i < SW/32; i++) s[i*32 +: 32] = $urandom;
    return s;
  endfunction
  task automatic check_bit(input string tag, input logic a, input logic e);
    checks++;
    assert (a === e) else begin
      errors++;
      $error("FAIL %s got=%b want=%b", tag, a, e);
    end
  endtask
  task automatic check_int(input string tag, input int a, input int e);
    checks++;
    assert (a === e) else begin
      errors++;
      $error("FAIL %s got=%0d want=%0d", tag, a, e);
    end
  endtask
  task automatic check_state(input string tag, input st_t a, input st_t e);
    int l = 0;
    for (int i = 24; i >= 0; i--) if (a[i*W +: W] !== e[i*W +: W]) l = i;
    checks++;
    assert (a === e) else begin
      errors++;
      $error("FAIL %s lane=%0d got=%h want=%h", tag, l, a[l*W +: W], e[l*W +: W]);
    end
  endtask
  task automatic send(input st_t s);
    int n = 0;
    in_valid = 1;
    state_in = s;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    check_bit("accept_ready", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) check_bit("busy_in_ready", in_ready, 1'b0);
      @(negedge clk);
      lat++;
    end
    check_int("latency", lat, 10);
  endtask
  task automatic xfer(input string tag, input st_t s, input st_t e);
    int lat;
    out_ready = 1;
    send(s);
    wait_valid(lat);
    check_state(tag, state_out, e);
    @(negedge clk);
    check_bit("retire_valid", out_valid, 1'b0);
    check_bit("retire_ready", in_ready, 1'b1);
  endtask
  st_t v [3];
  st_t e2, e3, held, a;
  st_t got [$];
  int  lat, idx;
  logic acc, ret;
  initial begin
    e2 = '0; e3 = '0; a = '0;
    for (int i = 0; i < 25; i++) begin
      if (i == 0 || i%5 == 1) e2[i*W +: W] = 64'h1;
      if (i%5 == 4)           e2[i*W +: W] = 64'h2;
      e3[i*W +: W] = (i%5 == 0 || i%5 == 4) ? 64'h5555_5555_5555_5555 :
                     (i%5 == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hAAAA_AAAA_AAAA_AAAA;
    end
    e3[0*W +: W] = 64'hFFFF_FFFF_FFFF_FFFF;
    e3[1*W +: W] = 64'h5555_5555_5555_5555;
    e3[2*W +: W] = 64'h0;
    for (int i = 0; i < 3; i++) a[i*W +: W] = 64'hAAAA_AAAA_AAAA_AAAA;
    repeat (2) @(negedge clk);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_in_ready", in_ready, 1'b0);
    check_state("rst_state_out", state_out, '0);
    rst = 0;
    xfer("t1_zero", '0, '0);
    xfer("t2_lane0", st_t'(64'h1), e2);
    xfer("t2_model", st_t'(64'h1), theta(st_t'(64'h1)));
    xfer("t3_aaaa", a, e3);
    v[0] = rand_state();
    out_ready = 0;
    send(v[0]);
    wait_valid(lat);
    held = state_out;
    check_state("t4_value", held, theta(v[0]));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_bit("t4_hold_valid", out_valid, 1'b1);
      check_bit("t4_hold_ready", in_ready, 1'b0);
      check_state("t4_hold_state", state_out, held);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check_bit("t4_release_valid", out_valid, 1'b0);
    check_bit("t4_release_ready", in_ready, 1'b1);
    @(negedge clk);
    check_bit("t4_single_xfer", out_valid, 1'b0);
    send(rand_state());
    repeat (7) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check_bit("t5_rst_valid", out_valid, 1'b0);
    check_bit("t5_rst_ready", in_ready, 1'b0);
    check_state("t5_rst_state", state_out, '0);
    rst = 0;
    @(negedge clk);
    check_bit("t5_ready_after", in_ready, 1'b1);
    xfer("t5_lane0", st_t'(64'h1), e2);
    for (int i = 0; i < 3; i++) v[i] = rand_state();
    idx = 0;
    in_valid = 1;
    state_in = v[0];
    for (int cyc = 0; cyc < 400 && got.size() < 3; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      acc = in_valid && in_ready;
      ret = out_valid && out_ready;
      if (ret) got.push_back(state_out);
      @(negedge clk);
      if (acc) begin
        idx++;
        if (idx < 3) state_in = v[idx]; else in_valid = 0;
      end
    end
    in_valid = 0;
    out_ready = 1;
    check_int("t6_count", got.size(), 3);
    for (int i = 0; i < 3 && i < got.size(); i++) check_state("t6_order", got[i], theta(v[i]));
    repeat (15) @(negedge clk);
    check_bit("t6_no_dup", out_valid, 1'b0);
    check_bit("t6_idle", in_ready, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
